// File: rtl/frame_tx_streamer_pkg.sv
// Shared types and constants for the frame-buffer byte streamer.
package frame_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    FETCH,
    WAIT_RD,
    SEND,
    CKSUM,
    DONE
  } state_e;

  localparam logic [7:0] SYNC0 = 8'hAA;
  localparam logic [7:0] SYNC1 = 8'h55;

  // Operands are zero-extended by the caller, so the sum cannot overflow.
  function automatic logic [31:0] luma(input logic [31:0] r, input logic [31:0] g,
                                       input logic [31:0] b);
    return (r + (g << 1) + b) >> 2;
  endfunction

endpackage

// File: rtl/frame_tx_streamer_if.sv
// Valid/ready byte stream from the streamer into the UART TX FIFO.
interface frame_tx_streamer_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/frame_tx_streamer_pixel_serializer.sv
// Splits one registered pixel word into bytes: all channels MSB-first, or a single luma byte.
module pixel_serializer
  import frame_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CH     = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         advance,
  input  logic                         gray,
  input  logic [DATA_WIDTH*NUM_CH-1:0] pix,
  output logic [DATA_WIDTH-1:0]        byte_data,
  output logic                         last_byte
);

  localparam int IDX_W = $clog2(NUM_CH + 1);

  logic [IDX_W-1:0]      byte_idx;
  logic [IDX_W-1:0]      idx_last;
  logic [DATA_WIDTH-1:0] rgb_byte;
  logic [DATA_WIDTH-1:0] gray_byte;

  assign idx_last  = gray ? '0 : IDX_W'(NUM_CH - 1);
  assign last_byte = (byte_idx == idx_last);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_idx <= '0;
    end else if (clear) begin
      byte_idx <= '0;
    end else if (advance) begin
      byte_idx <= last_byte ? '0 : byte_idx + IDX_W'(1);
    end
  end

  always_comb begin
    rgb_byte = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (IDX_W'(NUM_CH - 1 - c) == byte_idx) rgb_byte = pix[c*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  if (NUM_CH == 3) begin : g_luma
    assign gray_byte = DATA_WIDTH'(luma(32'(pix[2*DATA_WIDTH +: DATA_WIDTH]),
                                        32'(pix[DATA_WIDTH +: DATA_WIDTH]),
                                        32'(pix[0 +: DATA_WIDTH])));
  end else begin : g_top_ch
    assign gray_byte = pix[(NUM_CH-1)*DATA_WIDTH +: DATA_WIDTH];
  end

  assign byte_data = gray ? gray_byte : rgb_byte;

endmodule

// File: rtl/frame_tx_streamer.sv
// Frame-buffer to byte-stream sender with sync header, gray mode, abort and status.
// Optional trailing checksum byte when FRAME_TX_CKSUM_EN is defined.
module frame_tx_streamer
  import frame_tx_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_CH       = 3,
  parameter int TOTAL_PIXELS = 176*240,
  parameter int ADDR_WIDTH   = $clog2(TOTAL_PIXELS),
  parameter bit HDR_EN       = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         gray_mode,
  input  logic [DATA_WIDTH*NUM_CH-1:0] rData,
  output logic [ADDR_WIDTH-1:0]        rAddr,
  output logic                         oe,
  frame_tx_streamer_if.master          tx,
  output logic                         busy,
  output logic                         frame_done
);

  // state   | meaning
  // IDLE    | waiting for start
  // HEADER  | presenting sync bytes AA, 55
  // FETCH   | frame-buffer read issued for pix_cnt
  // WAIT_RD | read data returning, captured into pix_q
  // SEND    | serialising pix_q onto the byte stream
  // CKSUM   | presenting payload checksum (optional)
  // DONE    | one-cycle completion pulse

  localparam logic [ADDR_WIDTH-1:0] LAST_PIX = ADDR_WIDTH'(TOTAL_PIXELS - 1);

  state_e                       state;
  state_e                       state_nxt;
  logic [ADDR_WIDTH-1:0]        pix_cnt;
  logic [DATA_WIDTH*NUM_CH-1:0] pix_q;
  logic                         gray_q;
  logic                         hdr_sel;
  logic                         xfer;
  logic                         start_ok;
  logic                         pix_last;
  logic                         ser_last;
  logic [DATA_WIDTH-1:0]        ser_byte;

  assign xfer     = tx.out_valid && tx.out_ready;
  assign start_ok = (state == IDLE) && start && !abort;
  assign pix_last = (pix_cnt == LAST_PIX);
  assign rAddr    = pix_cnt;

  pixel_serializer #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_CH     (NUM_CH)
  ) u_ser (
    .clk       (clk),
    .reset     (reset),
    .clear     (start_ok || abort),
    .advance   ((state == SEND) && xfer),
    .gray      (gray_q),
    .pix       (pix_q),
    .byte_data (ser_byte),
    .last_byte (ser_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = HDR_EN ? HEADER : FETCH;
      HEADER:  if (xfer && hdr_sel) state_nxt = FETCH;
      FETCH:   state_nxt = WAIT_RD;
      WAIT_RD: state_nxt = SEND;
      SEND: begin
        if (xfer && ser_last) begin
          if (pix_last) begin
`ifdef FRAME_TX_CKSUM_EN
            state_nxt = CKSUM;
`else
            state_nxt = DONE;
`endif
          end else begin
            state_nxt = FETCH;
          end
        end
      end
      CKSUM:   if (xfer) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pix_cnt <= '0;
      pix_q   <= '0;
      gray_q  <= 1'b0;
      hdr_sel <= 1'b0;
    end else begin
      if (start_ok) gray_q <= gray_mode;
      // Cleared on abort/done too, so an idle streamer always addresses pixel 0.
      if (start_ok || abort || state == DONE) begin
        pix_cnt <= '0;
      end else if (state == SEND && xfer && ser_last && !pix_last) begin
        pix_cnt <= pix_cnt + ADDR_WIDTH'(1);
      end
      if (start_ok || abort)          hdr_sel <= 1'b0;
      else if (state == HEADER && xfer) hdr_sel <= !hdr_sel;
      if (state == WAIT_RD) pix_q <= rData;
    end
  end

`ifdef FRAME_TX_CKSUM_EN
  logic [DATA_WIDTH-1:0] cksum;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                        cksum <= '0;
    else if (start_ok)                 cksum <= '0;
    else if (state == SEND && xfer)    cksum <= cksum + ser_byte;
  end
`endif

  always_comb begin
    oe           = 1'b0;
    tx.out_valid = 1'b0;
    tx.out_data  = '0;
    busy         = 1'b1;
    frame_done   = 1'b0;
    case (state)
      IDLE:   busy = 1'b0;
      HEADER: begin
        tx.out_valid = 1'b1;
        tx.out_data  = hdr_sel ? DATA_WIDTH'(SYNC1) : DATA_WIDTH'(SYNC0);
      end
      FETCH:  oe = 1'b1;
      SEND: begin
        tx.out_valid = 1'b1;
        tx.out_data  = ser_byte;
      end
`ifdef FRAME_TX_CKSUM_EN
      CKSUM: begin
        tx.out_valid = 1'b1;
        tx.out_data  = cksum;
      end
`endif
      DONE: begin
        busy       = 1'b0;
        frame_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_frame_tx_streamer.sv
// Directed bench for frame_tx_streamer: 4-pixel RGB frame, gray, backpressure, abort, reset.
module tb_frame_tx_streamer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        gray_mode = 1'b0;
  logic [23:0] rData;
  logic [1:0]  rAddr;
  logic        oe;
  logic        busy;
  logic        frame_done;

  frame_tx_streamer_if #(.DATA_WIDTH(8)) tx ();

  frame_tx_streamer #(
    .DATA_WIDTH   (8),
    .NUM_CH       (3),
    .TOTAL_PIXELS (4),
    .HDR_EN       (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .gray_mode  (gray_mode),
    .rData      (rData),
    .rAddr      (rAddr),
    .oe         (oe),
    .tx         (tx.master),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  logic [23:0] mem [4] = '{24'h102030, 24'h405060, 24'h708090, 24'hA0B0C0};

  always @(posedge clk) if (oe) rData <= mem[rAddr];

  logic [7:0] exp_rgb [14] = '{8'hAA, 8'h55, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50,
                               8'h60, 8'h70, 8'h80, 8'h90, 8'hA0, 8'hB0, 8'hC0};
  logic [7:0] exp_gray [6] = '{8'hAA, 8'h55, 8'h20, 8'h50, 8'h80, 8'hB0};

`ifdef FRAME_TX_CKSUM_EN
  localparam int CKS = 1;
`else
  localparam int CKS = 0;
`endif

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Byte/pulse monitor, sampled mid-cycle away from the active edge.
  logic [7:0] rx_q [$];
  int         done_cnt = 0;
  logic       hold_pend = 1'b0;
  logic [7:0] held = 8'h00;

  always @(negedge clk) begin
    if (hold_pend) begin
      check("hold_valid", 32'(tx.out_valid), 32'd1);
      check("hold_data", 32'(tx.out_data), 32'(held));
    end
    if (tx.out_valid && tx.out_ready) rx_q.push_back(tx.out_data);
    if (frame_done) begin
      done_cnt <= done_cnt + 1;
      check("busy_at_done", 32'(busy), 32'd0);
    end
    hold_pend <= tx.out_valid && !tx.out_ready;
    held      <= tx.out_data;
  end

  task automatic cmp_stream(input string tag, input int base, input bit g);
    int n;
    n = g ? 6 : 14;
    check({tag, "_len"}, 32'(rx_q.size() - base), 32'(n + CKS));
    for (int i = 0; i < n; i++) begin
      if (base + i < rx_q.size())
        check({tag, "_byte"}, 32'(rx_q[base+i]), 32'(g ? exp_gray[i] : exp_rgb[i]));
    end
`ifdef FRAME_TX_CKSUM_EN
    if (base + n < rx_q.size())
      check({tag, "_cksum"}, 32'(rx_q[base+n]), g ? 32'hA0 : 32'hE0);
`endif
  endtask

  task automatic pulse_start(input bit g);
    @(posedge clk); #1;
    gray_mode = g;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic run_frame(input string tag, input bit g, input bit bp, input bit repulse);
    int base, dbase, lat;
    base  = rx_q.size();
    dbase = done_cnt;
    lat   = -1;
    pulse_start(g);
    for (int cyc = 0; cyc < 300 && lat < 0; cyc++) begin
      @(posedge clk); #1;
      tx.out_ready = bp ? (cyc % 3 == 2) : 1'b1;
      start        = repulse && (cyc == 6);
      if (cyc == 3) gray_mode = !g;
      if (done_cnt != dbase) lat = cyc;
    end
    tx.out_ready = 1'b1;
    start        = 1'b0;
    check({tag, "_timeout"}, 32'(lat >= 0), 32'd1);
    if (!bp) check({tag, "_latency"}, 32'(lat), 32'(2 + 4 * (2 + (g ? 1 : 3)) + CKS));
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_done_pulses"}, 32'(done_cnt - dbase), 32'd1);
    check({tag, "_busy_idle"}, 32'(busy), 32'd0);
    check({tag, "_raddr_idle"}, 32'(rAddr), 32'd0);
    cmp_stream(tag, base, g);
  endtask

  task automatic wait_bytes(input string tag, input int base, input int n);
    bit got_it;
    got_it = 1'b0;
    for (int cyc = 0; cyc < 100 && !got_it; cyc++) begin
      @(posedge clk); #1;
      if (rx_q.size() - base >= n) got_it = 1'b1;
    end
    check({tag, "_timeout"}, 32'(got_it), 32'd1);
  endtask

  initial begin
    int base, dbase;
    tx.out_ready = 1'b1;

    #12;
    check("rst_raddr", 32'(rAddr), 32'd0);
    check("rst_oe", 32'(oe), 32'd0);
    check("rst_data", 32'(tx.out_data), 32'd0);
    check("rst_valid", 32'(tx.out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);

    run_frame("rgb", 1'b0, 1'b0, 1'b0);
    run_frame("gray", 1'b1, 1'b0, 1'b0);
    run_frame("bp", 1'b0, 1'b1, 1'b0);
    run_frame("repulse", 1'b0, 1'b0, 1'b1);

    // Abort after the 5th byte: the streamer is between pixels, so nothing more may leave.
    base  = rx_q.size();
    dbase = done_cnt;
    pulse_start(1'b0);
    wait_bytes("abort_wait", base, 5);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_valid", 32'(tx.out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_oe", 32'(oe), 32'd0);
    check("abort_raddr", 32'(rAddr), 32'd0);
    repeat (30) @(posedge clk);
    #1;
    check("abort_len", 32'(rx_q.size() - base), 32'd5);
    check("abort_no_done", 32'(done_cnt - dbase), 32'd0);
    run_frame("after_abort", 1'b0, 1'b0, 1'b0);

    // Reset dropped in the middle of pixel 0 payload.
    base = rx_q.size();
    pulse_start(1'b0);
    wait_bytes("rst_mid_wait", base, 3);
    check("pre_rst_valid", 32'(tx.out_valid), 32'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_valid", 32'(tx.out_valid), 32'd0);
    check("mid_rst_data", 32'(tx.out_data), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_oe", 32'(oe), 32'd0);
    check("mid_rst_raddr", 32'(rAddr), 32'd0);
    check("mid_rst_done", 32'(frame_done), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    run_frame("after_rst", 1'b1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
